autoindex_sequencer: RTL and testbench

//  Sequences the operand-address phase of a memory-reference instruction for
//  the processor board. It takes the latched instruction and the PC and

---
 rtl/autoindex_sequencer_if.sv | 20 ++
 rtl/autoindex_sequencer.sv | 161 ++++++++++++++++
 tb/tb_autoindex_sequencer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/autoindex_sequencer_if.sv
// Memory bus for the operand-address sequencer.
// master = sequencer side, slave = memory side.
interface autoindex_sequencer_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/autoindex_sequencer.sv
// Effective-address sequencer: direct, indirect and
// post-increment autoindex operand resolution.
module autoindex_sequencer #(
    parameter int WAIT_MAX = 16
) (
    input  logic                         clk,
    input  logic                         nreset,
    input  logic                         start,
    input  logic [15:0]                  ir,
    input  logic [15:0]                  pc,
    autoindex_sequencer_if.master        mem,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [15:0]                  ea
);

    localparam int CW = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [15:0]   ptr_q, ptr_d;
    logic          aidx_q, aidx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [15:0]   ea_q, ea_d;

    logic [5:0]    page;
    logic [15:0]   oa;
    logic          aidx_in;
    logic          last_wait;

    assign page      = ir[10] ? 6'h00 : pc[15:10];
    assign oa        = {page, ir[9:0]};
    assign aidx_in   = ir[11] & ir[10] & (ir[9:8] == 2'b00) & ir[7];
    assign last_wait = (cnt_q == CNT_LAST);

    // Next-state and next-output computation for the sequencer
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ptr_d   = ptr_q;
        aidx_d  = aidx_q;
        cnt_d   = cnt_q;
        ea_d    = ea_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    aidx_d = aidx_in;
                    if (!ir[11]) begin
                        state_d = S_DONE;
                        ea_d    = oa;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RD;
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                        addr_d  = oa;
                        cnt_d   = '0;
                    end
                end
            end
            S_RD, S_WR: begin
                if (mem.mem_ack) begin
                    cnt_d = '0;
                    if (state_q == S_RD && aidx_q) begin
                        state_d = S_WR;
                        ptr_d   = mem.mem_rdata;
                        we_d    = 1'b1;
                        wdata_d = mem.mem_rdata + 16'd1;
                    end else begin
                        state_d = S_DONE;
                        req_d   = 1'b0;
                        we_d    = 1'b0;
                        done_d  = 1'b1;
                        ea_d    = (state_q == S_RD) ? mem.mem_rdata : ptr_q;
                    end
                end else if (last_wait) begin
                    // memory never answered: abandon, no write
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    cnt_d   = '0;
                    ea_d    = 16'h0000;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; reset drops the bus request at once
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            ptr_q   <= 16'h0000;
            aidx_q  <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ea_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ptr_q   <= ptr_d;
            aidx_q  <= aidx_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ea_q    <= ea_d;
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign ea            = ea_q;

endmodule

// File: tb/tb_autoindex_sequencer.sv
// Scoreboard bench for autoindex_sequencer with a
// behavioural memory and an address-mode reference model.
module tb_autoindex_sequencer;

    localparam int WAIT_MAX = 16;
    localparam int NEVER    = 1000;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] ir = 16'h0;
    logic [15:0] pc = 16'h0;
    logic        busy, done, err;
    logic [15:0] ea;

    autoindex_sequencer_if mif();

    autoindex_sequencer #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk    (clk),
        .nreset (nreset),
        .start  (start),
        .ir     (ir),
        .pc     (pc),
        .mem    (mif),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .ea     (ea)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] ea;
        logic        err;
        logic [31:0] lat;
        logic [31:0] nrd;
        logic [31:0] nwr;
        logic [15:0] caddr;
        logic [15:0] cval;
        logic [31:0] scyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    logic [15:0] mem_m [logic [15:0]];
    int cyc = 0;
    int rd_dly = 0;
    int wr_dly = 0;
    int rd_tot = 0;
    int wr_tot = 0;
    int rd_mark = 0;
    int wr_mark = 0;
    int npass = 0;
    int ntot = 0;

    function automatic logic [15:0] mrd(logic [15:0] a);
        return mem_m.exists(a) ? mem_m[a] : 16'h0000;
    endfunction

    function automatic logic [15:0] oa_of(logic [15:0] i_ir, logic [15:0] i_pc);
        logic [5:0] pg;
        pg = i_ir[10] ? 6'h00 : i_pc[15:10];
        return {pg, i_ir[9:0]};
    endfunction

    // Expected outcome from the addressing-mode rules
    function automatic exp_t model(logic [15:0] i_ir, logic [15:0] i_pc,
                                   int rdl, int wdl, int sc);
        exp_t e;
        logic [15:0] oa, p;
        logic aidx;
        oa = oa_of(i_ir, i_pc);
        aidx = i_ir[11] && i_ir[10] && (i_ir[9:8] == 2'b00) && i_ir[7];
        p = mrd(oa);
        e = '0;
        e.scyc = sc;
        e.caddr = oa;
        e.cval = p;
        if (!i_ir[11]) begin
            e.ea = oa;
            e.lat = 0;
        end else if (rdl >= WAIT_MAX) begin
            e.err = 1'b1;
            e.lat = WAIT_MAX;
        end else begin
            e.nrd = 1;
            e.lat = rdl + 1;
            if (!aidx) begin
                e.ea = p;
            end else if (wdl >= WAIT_MAX) begin
                e.err = 1'b1;
                e.lat = e.lat + WAIT_MAX;
            end else begin
                e.ea = p;
                e.nwr = 1;
                e.cval = p + 16'd1;
                e.lat = e.lat + wdl + 1;
            end
        end
        return e;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp_v);
        ntot++;
        if (act === exp_v) npass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp_v, $time);
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_mem_req"}, mif.mem_req, 0);
        chk({tag, "_mem_we"}, mif.mem_we, 0);
        chk({tag, "_mem_addr"}, mif.mem_addr, 0);
        chk({tag, "_mem_wdata"}, mif.mem_wdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_ea"}, ea, 0);
    endtask

    always @(posedge clk) cyc++;

    // Memory responder: ack after a programmable wait per access
    int  w = 0;
    logic ack_prev = 1'b0;
    logic req_prev = 1'b0;
    always @(negedge clk) begin
        if (!nreset || !mif.mem_req) begin
            mif.mem_ack = 1'b0;
            w = 0;
        end else begin
            if (ack_prev || !req_prev) w = 0;
            mif.mem_ack = (w >= (mif.mem_we ? wr_dly : rd_dly));
            mif.mem_rdata = mif.mem_ack ? mrd(mif.mem_addr) : 16'hDEAD;
            w++;
        end
        ack_prev = mif.mem_ack;
        req_prev = nreset && mif.mem_req;
    end

    // Memory side of completed handshakes
    always @(posedge clk) begin
        if (nreset && mif.mem_req && mif.mem_ack) begin
            if (mif.mem_we) begin
                mem_m[mif.mem_addr] = mif.mem_wdata;
                wr_tot++;
            end else begin
                rd_tot++;
            end
        end
    end

    // Monitor: pop and compare on every done pulse
    always @(negedge clk) begin
        if (!nreset) begin
            rd_mark = rd_tot;
            wr_mark = wr_tot;
        end else if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", sb.size(), 1);
            end else begin
                mon_e = sb.pop_front();
                chk("ea", ea, mon_e.ea);
                chk("err", err, mon_e.err);
                chk("latency", cyc - mon_e.scyc, mon_e.lat);
                chk("busy_with_done", busy, 1);
                chk("reads", rd_tot - rd_mark, mon_e.nrd);
                chk("writes", wr_tot - wr_mark, mon_e.nwr);
                chk("mem_after", mrd(mon_e.caddr), mon_e.cval);
            end
            rd_mark = rd_tot;
            wr_mark = wr_tot;
        end
    end

    // One accepted start (n_starts=1) or start held for 2*n_starts edges
    task automatic issue(logic [15:0] i_ir, logic [15:0] i_pc,
                         int rdl, int wdl, int n_starts);
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        rd_dly = rdl;
        wr_dly = wdl;
        ir = i_ir;
        pc = i_pc;
        if (n_starts == 1) begin
            sb.push_back(model(i_ir, i_pc, rdl, wdl, cyc + 1));
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end else begin
            for (int k = 0; k < n_starts; k++)
                sb.push_back(model(i_ir, i_pc, rdl, wdl, cyc + 1 + 2 * k));
            start = 1'b1;
            repeat (2 * n_starts) @(negedge clk);
            start = 1'b0;
        end
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("pending_done", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        int n;
        logic [15:0] r_ir, r_pc;
        int rdl, wdl, kind;
        mif.mem_ack = 1'b0;
        mif.mem_rdata = 16'h0;
        #2;
        check_zero("reset");
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);

        mem_m[16'h0085] = 16'h1234;
        issue(16'h0C85, 16'h0000, 0, 0, 1);
        mem_m[16'h00FF] = 16'hFFFF;
        issue(16'h0CFF, 16'h1234, 3, 3, 1);
        mem_m[16'h0100] = 16'hBEEF;
        issue(16'h0D00, 16'h4400, 0, 0, 1);
        mem_m[16'h4485] = 16'h7777;
        issue(16'h0885, 16'h4400, 0, 0, 1);
        issue(16'h0385, 16'h8000, 0, 0, 1);
        issue(16'h0385, 16'h8000, 0, 0, 3);

        issue(16'h0885, 16'h4400, NEVER, 0, 1);
        issue(16'h0885, 16'h4400, 15, 0, 1);
        mem_m[16'h0090] = 16'h0042;
        issue(16'h0C90, 16'h0000, 0, NEVER, 1);
        issue(16'h0C90, 16'h0000, 15, 15, 1);

        mem_m[16'h0090] = 16'h5555;
        rd_dly = 0;
        wr_dly = 6;
        ir = 16'h0C90;
        pc = 16'h0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(mif.mem_req && mif.mem_we) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reached_wr", mif.mem_req && mif.mem_we, 1);
        #2 nreset = 1'b0;
        #1;
        check_zero("midreset");
        chk("mem_untouched", mrd(16'h0090), 16'h5555);
        repeat (3) @(negedge clk);
        chk("mem_untouched_late", mrd(16'h0090), 16'h5555);
        nreset = 1'b1;
        @(negedge clk);
        issue(16'h0C90, 16'h0000, 0, 0, 1);

        for (int t = 0; t < 40; t++) begin
            r_ir = 16'($urandom);
            r_pc = 16'($urandom);
            kind = $urandom_range(0, 3);
            if (kind == 0) r_ir[11] = 1'b0;
            else if (kind == 1) r_ir = {4'h0, 2'b11, 2'b00, 1'b1, 7'($urandom)};
            else r_ir[11] = 1'b1;
            rdl = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
            wdl = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
            mem_m[oa_of(r_ir, r_pc)] = 16'($urandom);
            issue(r_ir, r_pc, rdl, wdl, 1);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
